// File: rtl/syn_io_resp_pkg.sv
// Shared types for the synapse I/O link (Syn_io_if) and its array-side responder.
//   Syn_op            : command opcode carried on client2syn_op
//   Eval_pattern      : one 4-bit correlation pattern
//   Syn_resp_tag      : {valid, channel, pat_ctr} carried alongside an in-flight array access
//   Syn_resp_state    : responder FSM states
//   NUM_EVAL_PATTERNS : number of patterns (and response beats) per EVAL command
package Syn_io;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_EVAL  = 2'd2,
    OP_RSVD  = 2'd3
  } Syn_op;

  typedef logic [3:0] Eval_pattern;

  typedef struct packed {
    logic       valid;
    logic       channel;   // 0 = read data, 1 = eval result
    logic [1:0] pat_ctr;
  } Syn_resp_tag;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } Syn_resp_state;

  localparam int NUM_EVAL_PATTERNS = 4;

endpackage

// File: rtl/syn_io_resp_if.sv
// Syn_io_if: command/response link between a synapse I/O sequencer (client)
// and the synapse-array responder (syn).
//   client2syn_* : command strobe, opcode, row address, write data, four eval patterns
//   syn2client_* : command accept, response beat strobe, channel, pattern index, data
// Modports: syn (responder side), client (sequencer side).
interface Syn_io_if #(
  parameter int REG_WIDTH  = 128,
  parameter int ADDR_WIDTH = 16
);
  import Syn_io::*;

  logic                    client2syn_valid;
  Syn_op                   client2syn_op;
  logic [ADDR_WIDTH-1:0]   client2syn_addr;
  logic [REG_WIDTH-1:0]    client2syn_data;
  Eval_pattern [0:3]       client2syn_patterns;

  logic                    syn2client_ready;
  logic                    syn2client_valid;
  logic                    syn2client_channel;
  logic [1:0]              syn2client_pat_ctr;
  logic [REG_WIDTH-1:0]    syn2client_data;

  modport syn (
    input  client2syn_valid, client2syn_op, client2syn_addr,
           client2syn_data, client2syn_patterns,
    output syn2client_ready, syn2client_valid, syn2client_channel,
           syn2client_pat_ctr, syn2client_data
  );

  modport client (
    output client2syn_valid, client2syn_op, client2syn_addr,
           client2syn_data, client2syn_patterns,
    input  syn2client_ready, syn2client_valid, syn2client_channel,
           syn2client_pat_ctr, syn2client_data
  );

endinterface

// File: rtl/syn_io_resp_pipe.sv
// syn_io_resp_pipe: fixed-depth delay line of response tags that tracks
// in-flight array accesses so each tag emerges in the cycle its data returns.
//   clk, reset : clock, synchronous active-high flush
//   tag_i      : tag of the access issued this cycle
//   tag_o      : tag of the access whose data is on arr_rdata this cycle
//   busy_o     : any tag still in flight
module syn_io_resp_pipe
  import Syn_io::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  Syn_resp_tag tag_i,
  output Syn_resp_tag tag_o,
  output logic        busy_o
);

  Syn_resp_tag stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
  end

endmodule

// File: rtl/syn_io_resp.sv
// syn_io_resp: synapse-array side responder of Syn_io_if. Accepts READ / WRITE /
// EVAL row commands, drives a fixed-latency array port and returns registered
// response beats tagged with channel and pattern index.
//   clk, reset   : clock, synchronous active-high reset
//   syn_io       : Syn_io_if.syn command/response link
//   arr_req/we/eval, arr_addr, arr_wdata, arr_pattern : array request port
//   arr_rdata    : array result, valid ARRAY_LATENCY cycles after arr_req
// Build option: SYN_IO_RESP_EVAL_EN. When undefined, EVAL skips the array and
// returns four all-zero eval beats; arr_eval and arr_pattern are tied to 0.
//
// state | meaning
// IDLE  | ready; capture command on valid
// ISSUE | drive array request(s), one per cycle (four for EVAL)
// DRAIN | wait until no tag is in flight
module syn_io_resp
  import Syn_io::*;
#(
  parameter int REG_WIDTH     = 128,
  parameter int ADDR_WIDTH    = 16,
  parameter int ARRAY_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  Syn_io_if.syn                 syn_io,
  output logic                  arr_req,
  output logic                  arr_we,
  output logic                  arr_eval,
  output logic [ADDR_WIDTH-1:0] arr_addr,
  output logic [REG_WIDTH-1:0]  arr_wdata,
  output logic [3:0]            arr_pattern,
  input  logic [REG_WIDTH-1:0]  arr_rdata
);

  // Keeps bit i iff i mod 4 == 3-k: pattern 0 maps to the MSB of each nibble.
  function automatic logic [REG_WIDTH-1:0] eval_mask(input logic [1:0] k);
    logic [REG_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < REG_WIDTH; i++) begin
      if (2'(i) == ~k) m[i] = 1'b1;
    end
    return m;
  endfunction

  Syn_resp_state         state_q, state_d;
  Syn_op                 op_q, op_d;
  logic [1:0]            k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  Syn_resp_tag           resp_tag_q, resp_tag_d;
  logic [REG_WIDTH-1:0]  resp_data_q, resp_data_d;

  Syn_resp_tag           issue_tag, pipe_tag, byp_tag;
  logic                  pipe_busy;
  logic                  ready;
  logic                  accept;
  logic                  eval_req;

`ifdef SYN_IO_RESP_EVAL_EN
  Eval_pattern [0:3]     pat_q, pat_d;
`else
  logic                  unused_patterns;
  assign unused_patterns = ^syn_io.client2syn_patterns;
`endif

  assign ready  = (state_q == ST_IDLE) && !reset;
  assign accept = syn_io.client2syn_valid && ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    k_d       = k_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef SYN_IO_RESP_EVAL_EN
    pat_d     = pat_q;
`endif
    arr_req   = 1'b0;
    arr_we    = 1'b0;
    eval_req  = 1'b0;
    issue_tag = '0;
    byp_tag   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = syn_io.client2syn_op;
          state_d = ST_ISSUE;
          // Only fields the op actually drives are captured, so the array
          // address/data/pattern lines keep their last driven value.
          unique case (syn_io.client2syn_op)
            OP_READ:  addr_d = syn_io.client2syn_addr;
            OP_WRITE: begin
              addr_d  = syn_io.client2syn_addr;
              wdata_d = syn_io.client2syn_data;
            end
            OP_EVAL: begin
              k_d = 2'd0;
`ifdef SYN_IO_RESP_EVAL_EN
              addr_d = syn_io.client2syn_addr;
              pat_d  = syn_io.client2syn_patterns;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        unique case (op_q)
          OP_READ: begin
            arr_req   = 1'b1;
            issue_tag = '{valid: 1'b1, channel: 1'b0, pat_ctr: 2'd0};
            state_d   = ST_DRAIN;
          end
          OP_WRITE: begin
            arr_req = 1'b1;
            arr_we  = 1'b1;
            state_d = ST_IDLE;
          end
          OP_EVAL: begin
`ifdef SYN_IO_RESP_EVAL_EN
            arr_req   = 1'b1;
            eval_req  = 1'b1;
            issue_tag = '{valid: 1'b1, channel: 1'b1, pat_ctr: k_q};
`else
            byp_tag   = '{valid: 1'b1, channel: 1'b1, pat_ctr: k_q};
`endif
            // k_q parks on the last index so arr_pattern holds its final value.
            if (k_q == 2'(NUM_EVAL_PATTERNS - 1)) state_d = ST_DRAIN;
            else                                  k_d     = k_q + 2'd1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  syn_io_resp_pipe #(.DEPTH(ARRAY_LATENCY)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_i  (issue_tag),
    .tag_o  (pipe_tag),
    .busy_o (pipe_busy)
  );

  always_comb begin
    resp_tag_d  = pipe_tag;
    resp_data_d = '0;
    if (pipe_tag.valid) begin
      resp_data_d = pipe_tag.channel ? (arr_rdata & eval_mask(pipe_tag.pat_ctr)) : arr_rdata;
    end
    if (byp_tag.valid) begin
      resp_tag_d  = byp_tag;
      resp_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      k_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_tag_q  <= resp_tag_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifdef SYN_IO_RESP_EVAL_EN
  always_ff @(posedge clk) begin
    if (reset) pat_q <= '0;
    else       pat_q <= pat_d;
  end
  assign arr_eval    = eval_req;
  assign arr_pattern = pat_q[k_q];
`else
  assign arr_eval    = eval_req;
  assign arr_pattern = 4'd0;
`endif

  assign arr_addr  = addr_q;
  assign arr_wdata = wdata_q;

  assign syn_io.syn2client_ready   = ready;
  assign syn_io.syn2client_valid   = resp_tag_q.valid;
  assign syn_io.syn2client_channel = resp_tag_q.channel;
  assign syn_io.syn2client_pat_ctr = resp_tag_q.pat_ctr;
  assign syn_io.syn2client_data    = resp_data_q;

endmodule
